// File: rtl/mem_line_master.sv
// Cache-side line bus initiator: turns a local request into a READ_LINE or WRITE_LINE
// burst on C2/D2/A2, waits for the memory RESPONSE and aborts after a timeout.
module mem_line_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int BEATS          = 8
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [14:0]  req_addr,
  input  logic [127:0] req_wdata,
  output logic         req_ready,
  output logic         resp_valid,
  output logic         resp_timeout,
  output logic [127:0] resp_rdata,
  output logic [14:0]  A2,
  inout  tri   [15:0]  D2,
  inout  tri   [1:0]   C2,
  output logic [2:0]   dbg_state
);

  // Local handshake: a request transfers on a rising clk edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE and req_valid is ignored
  // otherwise. resp_valid is a one-cycle pulse, resp_timeout qualifies it.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_WAIT = 3'd2,
    RD_DATA = 3'd3,
    WR_DATA = 3'd4,
    WR_WAIT = 3'd5
  } state_t;

  localparam logic [1:0] CMD_RESPONSE   = 2'd1;
  localparam logic [1:0] CMD_READ_LINE  = 2'd2;
  localparam logic [1:0] CMD_WRITE_LINE = 2'd3;
  localparam logic [2:0] LAST_BEAT      = 3'(BEATS - 1);
  localparam int         CW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [2:0]    beat;
  logic [CW-1:0] cnt;
  logic [111:0]  wd;      // write beats 1..7, shifted down one beat per cycle
  logic [111:0]  rbuf;    // read beats 0..6, shifted in from the top
  logic [1:0]    c2_q;
  logic          c2_oe;
  logic [15:0]   d2_q;
  logic          d2_oe;

  // A bus beat carries the even byte in its upper half.
  function automatic logic [15:0] swap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  assign C2        = c2_oe ? c2_q : 2'bzz;
  assign D2        = d2_oe ? d2_q : 16'bzzzz_zzzz_zzzz_zzzz;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state        <= IDLE;
      beat         <= '0;
      cnt          <= '0;
      wd           <= '0;
      rbuf         <= '0;
      c2_q         <= '0;
      c2_oe        <= 1'b0;
      d2_q         <= '0;
      d2_oe        <= 1'b0;
      A2           <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_timeout <= 1'b0;
      resp_rdata   <= '0;
    end else begin
      resp_valid   <= 1'b0;
      resp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            A2        <= req_addr;
            wd        <= req_wdata[127:16];
            req_ready <= 1'b0;
            beat      <= '0;
            c2_oe     <= 1'b1;
            if (req_write) begin
              state <= WR_DATA;
              c2_q  <= CMD_WRITE_LINE;
              d2_q  <= swap(req_wdata[15:0]);
              d2_oe <= 1'b1;
            end else begin
              state <= RD_CMD;
              c2_q  <= CMD_READ_LINE;
            end
          end
        end

        RD_CMD: begin
          state <= RD_WAIT;
          c2_oe <= 1'b0;
          cnt   <= '0;
        end

        RD_WAIT: begin
          // Only a driven RESPONSE code counts; z/x never match 4-state equality.
          if (C2 === CMD_RESPONSE) begin
            rbuf  <= {swap(D2), rbuf[111:16]};
            beat  <= 3'd1;
            state <= RD_DATA;
          end else if (cnt == CNT_LAST) begin
            resp_valid   <= 1'b1;
            resp_timeout <= 1'b1;
            req_ready    <= 1'b1;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RD_DATA: begin
          if (beat == LAST_BEAT) begin
            resp_rdata <= {swap(D2), rbuf};
            resp_valid <= 1'b1;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end else begin
            rbuf <= {swap(D2), rbuf[111:16]};
            beat <= beat + 3'd1;
          end
        end

        WR_DATA: begin
          if (beat == LAST_BEAT) begin
            state <= WR_WAIT;
            c2_oe <= 1'b0;
            d2_oe <= 1'b0;
            cnt   <= '0;
          end else begin
            d2_q <= swap(wd[15:0]);
            wd   <= wd >> 16;
            beat <= beat + 3'd1;
          end
        end

        WR_WAIT: begin
          if (C2 === CMD_RESPONSE) begin
            resp_valid <= 1'b1;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end else if (cnt == CNT_LAST) begin
            resp_valid   <= 1'b1;
            resp_timeout <= 1'b1;
            req_ready    <= 1'b1;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          c2_oe     <= 1'b0;
          d2_oe     <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_master.sv
// Bench for mem_line_master: table of line transactions against a small memory
// responder, plus hand sequences for reset mid-burst and back-to-back acceptance.
module tb_mem_line_master;

  logic         clk;
  logic         RESET;
  logic         req_valid;
  logic         req_write;
  logic [14:0]  req_addr;
  logic [127:0] req_wdata;
  logic         req_ready;
  logic         resp_valid;
  logic         resp_timeout;
  logic [127:0] resp_rdata;
  logic [14:0]  A2;
  logic [2:0]   dbg_state;
  tri   [15:0]  D2;
  tri   [1:0]   C2;

  logic         mem_c2_oe;
  logic [1:0]   mem_c2;
  logic         mem_d2_oe;
  logic [15:0]  mem_d2;

  assign C2 = mem_c2_oe ? mem_c2 : 2'bzz;
  assign D2 = mem_d2_oe ? mem_d2 : 16'bzzzz_zzzz_zzzz_zzzz;

  int n_checks;
  int n_fail;

  mem_line_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .RESET(RESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_timeout(resp_timeout),
    .resp_rdata(resp_rdata), .A2(A2), .D2(D2), .C2(C2), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic             write;
    logic             silent;
    logic [14:0]      addr;
    logic [127:0]     wdata;
    logic [7:0][15:0] beats;
    int               delay;
    int               exp_cyc;
    logic             exp_to;
    logic [127:0]     exp_rdata;
  } vec_t;

  vec_t vecs [7];

  localparam logic [127:0] L1 = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [127:0] L2 = 128'h100F0E0D0C0B0A090807060504030201;
  localparam logic [127:0] L3 = 128'h5AA55AA55AA55AA55AA55AA55AA55AA5;
  localparam logic [127:0] W1 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] W2 = 128'h112233445566778899AABBCCDDEEFF00;
  localparam logic [7:0][15:0] B1 = {16'hEEFF, 16'hCCDD, 16'hAABB, 16'h8899,
                                      16'h6677, 16'h4455, 16'h2233, 16'h0011};
  localparam logic [7:0][15:0] B2 = {16'h0F10, 16'h0D0E, 16'h0B0C, 16'h090A,
                                      16'h0708, 16'h0506, 16'h0304, 16'h0102};
  localparam logic [7:0][15:0] B3 = {8{16'hA55A}};
  localparam logic [7:0][15:0] BW1 = {16'h0E0F, 16'h0C0D, 16'h0A0B, 16'h0809,
                                       16'h0607, 16'h0405, 16'h0203, 16'h0001};
  localparam logic [7:0][15:0] BW2 = {16'h2211, 16'h4433, 16'h6655, 16'h8877,
                                       16'hAA99, 16'hCCBB, 16'hEEDD, 16'h00FF};

  function automatic vec_t mk(input logic wr, input logic sil, input logic [14:0] a,
                              input logic [127:0] wdat, input logic [7:0][15:0] b,
                              input int d, input int cyc, input logic to, input logic [127:0] rd);
    vec_t v;
    v.write = wr; v.silent = sil; v.addr = a; v.wdata = wdat; v.beats = b;
    v.delay = d; v.exp_cyc = cyc; v.exp_to = to; v.exp_rdata = rd;
    return v;
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Memory responder drive for cycle c (cycle 1 follows the acceptance edge).
  task automatic mem_cycle(input vec_t v, input int c);
    int r;
    mem_c2_oe = 1'b0;
    mem_d2_oe = 1'b0;
    if (!v.silent) begin
      if (!v.write) begin
        r = 2 + v.delay;
        if (c >= r && c < r + 8) begin
          mem_c2_oe = 1'b1;
          mem_c2    = (c == r) ? 2'd1 : 2'd0;
          mem_d2_oe = 1'b1;
          mem_d2    = v.beats[c - r];
        end
      end else if (c == 9 + v.delay) begin
        mem_c2_oe = 1'b1;
        mem_c2    = 2'd1;
      end
    end
  endtask

  // driver: one full transaction with its checks
  task automatic run_vec(input vec_t v, input string tag);
    int c, cmd, nw;
    bit done;
    logic [15:0] got [8];
    @(negedge clk); #1;
    check({tag, "_ready_idle"}, 128'(req_ready), 128'd1);
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    c = 1; cmd = 0; nw = 0; done = 1'b0;
    while (!done && c <= 60) begin
      mem_cycle(v, c);
      #1;
      if (c == 1) check({tag, "_a2"}, 128'(A2), 128'(v.addr));
      if (C2 === 2'd2) cmd++;
      if (C2 === 2'd3) begin
        if (nw < 8) got[nw] = D2;
        nw++;
      end
      if (resp_valid === 1'b1) done = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    check({tag, "_resp_seen"}, 128'(done), 128'd1);
    check({tag, "_latency"}, 128'(c), 128'(v.exp_cyc));
    check({tag, "_timeout"}, 128'(resp_timeout), 128'(v.exp_to));
    check({tag, "_rdata"}, resp_rdata, v.exp_rdata);
    check({tag, "_ready_resp"}, 128'(req_ready), 128'd1);
    if (v.write) begin
      check({tag, "_wr_beats"}, 128'(nw), 128'd8);
      for (int i = 0; i < 8; i++) check({tag, "_wr_d2"}, 128'(got[i]), 128'(v.beats[i]));
    end else begin
      check({tag, "_rd_cmd_cycles"}, 128'(cmd), 128'd1);
      check({tag, "_rd_no_wr"}, 128'(nw), 128'd0);
    end
  endtask

  initial begin
    vec_t v;
    int c, cmd;
    bit done;
    n_checks = 0; n_fail = 0;
    RESET = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_c2_oe = 1'b0; mem_c2 = '0; mem_d2_oe = 1'b0; mem_d2 = '0;

    vecs[0] = mk(1'b0, 1'b0, 15'h1234, '0, B1,  3, 13, 1'b0, L1);
    vecs[1] = mk(1'b1, 1'b0, 15'h7FFF, W1, BW1, 2, 12, 1'b0, L1);
    vecs[2] = mk(1'b0, 1'b0, 15'h0001, '0, B2,  0, 10, 1'b0, L2);
    vecs[3] = mk(1'b0, 1'b1, 15'h2AAA, '0, '0,  0, 18, 1'b1, L2);
    vecs[4] = mk(1'b1, 1'b0, 15'h0ABC, W2, BW2, 0, 10, 1'b0, L2);
    vecs[5] = mk(1'b1, 1'b1, 15'h5555, W2, BW2, 0, 25, 1'b1, L2);
    vecs[6] = mk(1'b0, 1'b0, 15'h4000, '0, B3,  5, 15, 1'b0, L3);

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 128'(req_ready), 128'd1);
    check("rst_resp_valid", 128'(resp_valid), 128'd0);
    check("rst_rdata", resp_rdata, 128'd0);
    check("rst_a2", 128'(A2), 128'd0);
    check("rst_state", 128'(dbg_state), 128'd0);
    @(negedge clk);
    RESET = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset in the middle of a read burst, after beat 3
    v = mk(1'b0, 1'b0, 15'h0100, '0, B1, 0, 10, 1'b0, L1);
    @(negedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = v.addr;
    @(negedge clk);
    req_valid = 1'b0;
    for (int cc = 1; cc <= 5; cc++) begin
      mem_cycle(v, cc);
      @(negedge clk);
    end
    mem_c2_oe = 1'b0; mem_d2_oe = 1'b0;
    RESET = 1'b0;
    #1;
    check("mid_rd_rst_ready", 128'(req_ready), 128'd1);
    check("mid_rd_rst_valid", 128'(resp_valid), 128'd0);
    check("mid_rd_rst_rdata", resp_rdata, 128'd0);
    check("mid_rd_rst_a2", 128'(A2), 128'd0);
    check("mid_rd_rst_state", 128'(dbg_state), 128'd0);
    @(negedge clk);
    RESET = 1'b1;

    // reset in the middle of a write burst: the data and command buses let go at once
    @(negedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0222; req_wdata = W1;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("mid_wr_driving_c2", 128'(C2), 128'd3);
    RESET = 1'b0;
    #1;
    check("mid_wr_rst_d2_released", 128'($isunknown(D2) || (D2 == 16'h0)), 128'd1);
    check("mid_wr_rst_c2_released", 128'($isunknown(C2) || (C2 == 2'h0)), 128'd1);
    @(negedge clk);
    RESET = 1'b1;
    run_vec(vecs[2], "post_rst_rd");

    // req_valid held through a read with req_write toggling; next request taken at resp edge
    v = mk(1'b0, 1'b0, 15'h0033, '0, B1, 0, 10, 1'b0, L1);
    @(negedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = v.addr;
    c = 0; cmd = 0; done = 1'b0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      mem_cycle(v, c);
      req_write = c[0];
      #1;
      if (C2 === 2'd2) cmd++;
      if (resp_valid === 1'b1) done = 1'b1;
    end
    check("hold_resp_seen", 128'(done), 128'd1);
    check("hold_latency", 128'(c), 128'd10);
    check("hold_rd_cmd_cycles", 128'(cmd), 128'd1);
    check("hold_rdata", resp_rdata, L1);
    req_write = 1'b1; req_addr = 15'h0777; req_wdata = W1;
    @(negedge clk);
    mem_c2_oe = 1'b0; mem_d2_oe = 1'b0;
    req_valid = 1'b0;
    #1;
    check("b2b_wr_c2", 128'(C2), 128'd3);
    check("b2b_wr_d2", 128'(D2), 128'h0001);
    check("b2b_wr_a2", 128'(A2), 128'h0777);
    check("b2b_ready_low", 128'(req_ready), 128'd0);
    check("b2b_state", 128'(dbg_state), 128'd4);
    v = mk(1'b1, 1'b0, 15'h0777, W1, BW1, 0, 10, 1'b0, L1);
    c = 1; done = 1'b0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      mem_cycle(v, c);
      #1;
      if (resp_valid === 1'b1) done = 1'b1;
    end
    check("b2b_wr_resp_seen", 128'(done), 128'd1);
    check("b2b_wr_latency", 128'(c), 128'd10);
    check("b2b_wr_rdata_kept", resp_rdata, L1);
    @(negedge clk);
    mem_c2_oe = 1'b0; mem_d2_oe = 1'b0;

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
